// File: rtl/mul_issue_wb.sv
// mul_issue_wb: issue/writeback wrapper around a registered 32x32 signed
// multiplier. Requests are issued through S1 (drives the multiplier
// operands), wait one cycle in S2 while the product registers fill, and the
// corrected result word is written in order into a small output FIFO.
// A credit check on FIFO occupancy plus in-flight ops guarantees that every
// result has a FIFO slot when it arrives.
module mul_issue_wb #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic [1:0]       mul_en,
    input  logic [31:0]      mul_l,
    input  logic [31:0]      mul_h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   CREDIT   = (CNT_W + 1)'(DEPTH);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Pipeline registers
    logic             s1_v_reg;
    logic [1:0]       s1_op_reg;
    logic [31:0]      s1_a_reg;
    logic [31:0]      s1_b_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             s2_v_reg;
    logic [1:0]       s2_op_reg;
    logic [31:0]      s2_a_reg;
    logic [31:0]      s2_b_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    // Output FIFO
    logic [31:0]      fifo_data_reg [DEPTH];
    logic [TAG_W-1:0] fifo_tag_reg  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;
    logic [31:0]      result_next;
    logic [31:0]      corr_a_term;
    logic [31:0]      corr_b_term;

    // Credit is derived purely from registered state so in_ready never
    // depends combinationally on in_valid or out_ready.
    assign occupancy = {1'b0, count_reg}
                     + {{CNT_W{1'b0}}, s1_v_reg}
                     + {{CNT_W{1'b0}}, s2_v_reg};
    assign in_ready  = (occupancy < CREDIT);
    assign accept    = in_valid & in_ready;

    assign push      = s2_v_reg;
    assign pop       = out_valid & out_ready;

    assign mul_a     = s1_a_reg;
    assign mul_b     = s1_b_reg;
    assign mul_en    = {s1_v_reg, s1_v_reg};

    assign out_valid = (count_reg != '0);
    assign out_data  = fifo_data_reg[rd_ptr_reg];
    assign out_tag   = fifo_tag_reg[rd_ptr_reg];
    assign busy      = s1_v_reg | s2_v_reg | (count_reg != '0);

    // S1 issue register: loads on acceptance, otherwise just drops valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_reg   <= 1'b0;
            s1_op_reg  <= '0;
            s1_a_reg   <= '0;
            s1_b_reg   <= '0;
            s1_tag_reg <= '0;
        end else begin
            s1_v_reg <= accept;
            if (accept) begin
                s1_op_reg  <= in_op;
                s1_a_reg   <= in_a;
                s1_b_reg   <= in_b;
                s1_tag_reg <= in_tag;
            end
        end
    end

    // S2 product-wait register: shadows S1 while the multiplier captures.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v_reg   <= 1'b0;
            s2_op_reg  <= '0;
            s2_a_reg   <= '0;
            s2_b_reg   <= '0;
            s2_tag_reg <= '0;
        end else begin
            s2_v_reg   <= s1_v_reg;
            s2_op_reg  <= s1_op_reg;
            s2_a_reg   <= s1_a_reg;
            s2_b_reg   <= s1_b_reg;
            s2_tag_reg <= s1_tag_reg;
        end
    end

    // Turn the signed product into the requested word; an operand treated
    // as unsigned with its top bit set adds the other operand to the high word.
    always_comb begin
        corr_a_term = s2_a_reg[31] ? s2_b_reg : 32'd0;
        corr_b_term = s2_b_reg[31] ? s2_a_reg : 32'd0;
        result_next = mul_l;
        case (s2_op_reg)
            OP_MUL:    result_next = mul_l;
            OP_MULH:   result_next = mul_h;
            OP_MULHSU: result_next = mul_h + corr_b_term;
            OP_MULHU:  result_next = mul_h + corr_a_term + corr_b_term;
            default:   result_next = mul_l;
        endcase
    end

    // One storage slot per FIFO entry, written when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_tag_reg[gi]  <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    fifo_data_reg[gi] <= result_next;
                    fifo_tag_reg[gi]  <= s2_tag_reg;
                end
            end
        end
    endgenerate

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // FIFO pointers (explicit wrap so non-power-of-two depths work) and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_wb.sv
// Testbench for mul_issue_wb: models the registered multiplier, keeps a
// transaction-level reference queue checked every cycle, and runs directed
// vectors with hand-computed results.
module tb_mul_issue_wb;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [1:0]       mul_en;
    logic [31:0]      mul_l = '0;
    logic [31:0]      mul_h = '0;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mul_issue_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_en    (mul_en),
        .mul_l     (mul_l),
        .mul_h     (mul_h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered signed multiplier seen by the DUT.
    logic [63:0] mprod;
    assign mprod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    always @(posedge clk) begin
        if (mul_en[0]) mul_l <= mprod[31:0];
        if (mul_en[1]) mul_h <= mprod[63:32];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain 64-bit arithmetic on extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = op[1] ? {32'd0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic [31:0]      b;
        int               acc_edge;
    } exp_t;

    exp_t model_q[$];
    exp_t ne;
    int   mq_n;
    logic exp_valid;
    logic exp_s1;

    // Every-cycle comparison against the reference queue. An op accepted at
    // clock edge e sits in the issue stage after e and is visible at the
    // output after edge e+2; it counts against credit until popped.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_mul_en", 32'(mul_en), 32'd0);
            check("rst_out_data", out_data, 32'd0);
            model_q.delete();
        end else begin
            mq_n      = model_q.size();
            exp_valid = (mq_n > 0) && (cyc >= model_q[0].acc_edge + 2);
            exp_s1    = (mq_n > 0) && (model_q[mq_n-1].acc_edge == cyc);
            check("in_ready", 32'(in_ready), 32'(mq_n < DEPTH));
            check("busy", 32'(busy), 32'(mq_n != 0));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("mul_en", 32'(mul_en), exp_s1 ? 32'd3 : 32'd0);
            if (exp_s1) begin
                check("mul_a", mul_a, model_q[mq_n-1].a);
                check("mul_b", mul_b, model_q[mq_n-1].b);
            end
            if (exp_valid) begin
                check("out_data", out_data, model_q[0].data);
                check("out_tag", 32'(out_tag), 32'(model_q[0].tag));
                if (out_ready) begin
                    $display("pop  cyc=%0d data=0x%08h tag=%0d", cyc, out_data, out_tag);
                    void'(model_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                ne.data     = ref_mul(in_op, in_a, in_b);
                ne.tag      = in_tag;
                ne.a        = in_a;
                ne.b        = in_b;
                ne.acc_edge = cyc + 1;
                model_q.push_back(ne);
                $display("acc  cyc=%0d op=%0d a=0x%08h b=0x%08h tag=%0d", cyc, in_op, in_a, in_b, in_tag);
            end
        end
    end

    // Single op with out_ready high: literal result, 3-cycle latency, busy drops after.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp_data);
        int  acc;
        bit  seen;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        @(negedge clk);
        acc = cyc;
        check({name, "_accept"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_latency"}, 32'(cyc - acc), 32'd3);
            check({name, "_data"}, out_data, exp_data);
            check({name, "_tag"}, 32'(out_tag), 32'(tag));
            @(negedge clk);
            check({name, "_busy_after"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_acc;
    int n_pop;
    int first_pop;
    int last_pop;
    int first_acc;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_mul_a", mul_a, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b1;

        // Directed single ops
        run_op("mul_7x-3",      2'b00, 32'd7,          32'hFFFFFFFD, 4'd1, 32'hFFFFFFEB);
        run_op("mulh_min_min",  2'b01, 32'h80000000,   32'h80000000, 4'd2, 32'h40000000);
        run_op("mulh_m1x2",     2'b01, 32'hFFFFFFFF,   32'h00000002, 4'd3, 32'hFFFFFFFF);
        run_op("mulhu_max",     2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE);
        run_op("mulhsu_max",    2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF, 4'd5, 32'hFFFFFFFF);
        run_op("mulhu_2p16",    2'b11, 32'h00010000,   32'h00010000, 4'd6, 32'h00000001);

        // Backpressure: six offers, only DEPTH fit
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_op    = 2'b00;
            in_a     = 32'(i);
            in_b     = 32'(i);
            in_tag   = TAG_W'(i);
            @(negedge clk);
            if (in_ready) n_acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", 32'(n_acc), 32'd4);
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'(j * j));
            check("bp_tag", 32'(out_tag), 32'(j));
            if (j == 0) check("bp_ready_at_pop", 32'(in_ready), 32'd0);
            if (j == 1) check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Streaming: 16 ops on consecutive cycles
        n_pop     = 0;
        first_pop = 0;
        last_pop  = 0;
        first_acc = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (c < 16) begin
                in_valid = 1'b1;
                in_op    = 2'(c);
                in_a     = (c < 4) ? 32'h80000000 : $urandom;
                in_b     = (c < 2) ? 32'hFFFFFFFF : $urandom;
                in_tag   = TAG_W'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 0) first_acc = cyc;
            if (c < 16) check("stream_accept", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (n_pop == 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
        end
        check("stream_count", 32'(n_pop), 32'd16);
        check("stream_first_latency", 32'(first_pop - first_acc), 32'd3);
        check("stream_contiguous", 32'(last_pop - first_pop), 32'd15);

        // Reset with two ops in the pipe and two buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_op    = 2'b00;
            in_a     = 32'(i + 10);
            in_b     = 32'd2;
            in_tag   = TAG_W'(i + 8);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_mul_en", 32'(mul_en), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 4'd7, 32'd15);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
